down_timer: RTL

Loadable, cascadable down-counting timer: the count-down counterpart to the team's up counter. It loads a start value, decrements on each enabled clock, and flags terminal count on a ripple output that cascades like the up counter's `rco`. A small control FSM adds a start/stop/done/ack handshake so a controller can fire one-shot delays, or periodic ticks when auto-reload is compiled in.

---
 rtl/down_timer_pkg.sv | 15 +
 rtl/down_counter_core.sv | 44 ++++
 rtl/down_timer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/down_timer_pkg.sv
// down_timer_pkg: shared definitions for the down_timer block.
// Contents:
//   state_t              : control FSM state encoding (IDLE/RUN/DONE)
//   DOWN_TIMER_N_DEFAULT : default counter width
package down_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DOWN_TIMER_N_DEFAULT = 4;

endpackage

// File: rtl/down_counter_core.sv
// down_counter_core: N-bit count register with synchronous load and
// decrement, plus a zero-detect flag.
// Ports:
//   clk  : system clock
//   clr  : asynchronous active-high reset, clears the count
//   load : load din this edge (wins over dec)
//   dec  : decrement this edge
//   din  : load value
//   cnt  : current count (straight from the register)
//   zero : cnt == 0
// The caller never asserts dec with cnt == 0, so there is no wrap guard here.
module down_counter_core
    import down_timer_pkg::*;
#(
    parameter int N = DOWN_TIMER_N_DEFAULT
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic         dec,
    input  logic [N-1:0] din,
    output logic [N-1:0] cnt,
    output logic         zero
);

    logic [N-1:0] cnt_r;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_r <= {N{1'b0}};
        end else if (load) begin
            cnt_r <= din;
        end else if (dec) begin
            cnt_r <= cnt_r - N'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign zero = (cnt_r == {N{1'b0}});

endmodule

// File: rtl/down_timer.sv
// down_timer: loadable, cascadable down-counting timer with a
// start/stop/done/ack handshake.
// Ports:
//   clk   : system clock
//   clr   : asynchronous active-high reset
//   start : load din into count (and reload), enter RUN
//   stop  : leave RUN for IDLE, count holds
//   ack   : acknowledge DONE, return to IDLE
//   din   : start/reload value
//   enp   : parallel count enable (does not gate tc)
//   ent   : trickle count enable (gates tc)
//   dout  : current count
//   tc    : terminal count, (dout==0) & ent & busy
//   busy  : FSM in RUN
//   done  : FSM in DONE
// Build option: DOWN_TIMER_AUTO_RELOAD_EN -- when defined, reaching zero
// reloads the last start value and the timer stays in RUN (periodic mode);
// DONE is then never entered.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int N = DOWN_TIMER_N_DEFAULT
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic         stop,
    input  logic         ack,
    input  logic [N-1:0] din,
    input  logic         enp,
    input  logic         ent,
    output logic [N-1:0] dout,
    output logic         tc,
    output logic         busy,
    output logic         done
);

    state_t       state_r;
    state_t       state_nx_s;
    logic         load_s;
    logic         dec_s;
    logic [N-1:0] load_val_s;
    logic         zero_s;
    logic         busy_s;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic         take_din_s;
    logic [N-1:0] reload_r;

    // Reload register captures din on every accepted start.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            reload_r <= {N{1'b0}};
        end else if (take_din_s) begin
            reload_r <= din;
        end else begin
            reload_r <= reload_r;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and counter control; in RUN stop beats start beats counting.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        dec_s      = 1'b0;
        load_val_s = din;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        take_din_s = 1'b0;
`endif
        unique case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_RUN;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                    take_din_s = 1'b1;
`endif
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nx_s = ST_IDLE;
                end else if (start) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_RUN;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                    take_din_s = 1'b1;
`endif
                end else if (enp && ent) begin
                    if (!zero_s) begin
                        dec_s      = 1'b1;
                        state_nx_s = ST_RUN;
                    end else begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                        load_s     = 1'b1;
                        load_val_s = reload_r;
                        state_nx_s = ST_RUN;
`else
                        // Count already at zero, so DONE shows dout==0.
                        state_nx_s = ST_DONE;
`endif
                    end
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: begin
                // start is deliberately ignored here, even alongside ack.
                if (ack) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    down_counter_core #(.N(N)) u_core (
        .clk  (clk),
        .clr  (clr),
        .load (load_s),
        .dec  (dec_s),
        .din  (load_val_s),
        .cnt  (dout),
        .zero (zero_s)
    );

    // Status decodes straight from the state register; tc adds only ent,
    // so an upper stage can take ent from this stage's tc.
    assign busy_s = (state_r == ST_RUN);
    assign busy   = busy_s;
    assign done   = (state_r == ST_DONE);
    assign tc     = zero_s & ent & busy_s;

endmodule
